// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and defaults for the tri-state bus arbiter and its
// round-robin selector.
package tri_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int N_DEF       = 4;
  localparam int MAXHOLD_DEF = 8;
  localparam int GAP_DEF     = 1;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_select.sv
// Round-robin priority selector: the first requester at or after the
// pointer (modulo N) wins.
module rr_select
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [id_width(N)-1:0] ptr_i,
  input  logic [N-1:0]           req_i,
  output logic [id_width(N)-1:0] idx_o,
  output logic                   valid_o
);

  localparam int W = id_width(N);

  logic [W-1:0] cand_s;

  // Scan from the farthest candidate down so the nearest one is assigned last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = W'((int'(ptr_i) + k) % N);
      if (req_i[cand_s]) begin
        idx_o   = cand_s;
        valid_o = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Three-state arbiter for a shared tri-state bus: one-hot driver enables,
// bounded hold time and a fixed all-off turnaround between grants.
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAXHOLD = MAXHOLD_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  output logic [N-1:0]           en,
  output logic [id_width(N)-1:0] gnt_id,
  output logic                   busy
);

  localparam int W  = id_width(N);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int TW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e        state_q, state_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [W-1:0]  gnt_q, gnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [N-1:0]  en_q, en_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  sel_idx_s;
  logic          sel_valid_s;
  logic          grant_s;
  logic [W-1:0]  ptr_nxt_s;

  rr_select #(.N(N)) u_rr_select (
    .ptr_i   (ptr_q),
    .req_i   (req),
    .idx_o   (sel_idx_s),
    .valid_o (sel_valid_s)
  );

  assign ptr_nxt_s = (gnt_q == W'(N - 1)) ? '0 : gnt_q + W'(1);

  // Next-state and registered-output decode; a grant from IDLE or the last
  // TURN cycle shares one path so both behave identically.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    en_d    = en_q;
    busy_d  = busy_q;
    grant_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          grant_s = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        // A coincident request drop and expiry is the same single release.
        if (!req[gnt_q] || (hold_q == HW'(MAXHOLD - 1))) begin
          en_d    = '0;
          ptr_d   = ptr_nxt_s;
          turn_d  = '0;
          state_d = TURN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == TW'(GAP - 1)) begin
          if (sel_valid_s) begin
            grant_s = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (grant_s) begin
      en_d            = '0;
      en_d[sel_idx_s] = 1'b1;
      gnt_d           = sel_idx_s;
      hold_d          = '0;
      busy_d          = 1'b1;
      state_d         = GRANT;
    end else begin
      grant_s = 1'b0;
    end
  end

  // State and output registers; reset drops every driver enable at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign en     = en_q;
  assign gnt_id = gnt_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a bus-ownership model.
module tb_tri_bus_arbiter;

  localparam int N       = 4;
  localparam int MAXHOLD = 8;
  localparam int GAP     = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] en;
  logic [1:0]   gnt_id;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  tri_bus_arbiter #(.N(N), .MAXHOLD(MAXHOLD), .GAP(GAP)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .en     (en),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bus-ownership model: who owns the bus, for how long, and how many
  // quiet cycles remain before the next decision.
  int m_owner = -1;
  int m_held  = 0;
  int m_quiet = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_quiet = 0; m_ptr = 0; m_last = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (((req >> m_owner) & 4'b0001) == 4'b0000 || m_held >= MAXHOLD) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_quiet = GAP;
      end
    end else begin
      if (m_quiet > 0) m_quiet--;
      if (m_quiet == 0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && ((req >> c) & 4'b0001) != 4'b0000) begin
            found   = 1'b1;
            m_owner = c;
            m_held  = 0;
            m_last  = c;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model plus bus-safety properties.
  int           zero_run   = 100;
  logic [N-1:0] last_en_nz = '0;

  always @(negedge clk) begin
    logic [N-1:0] exp_en;
    if (!rst) begin
      exp_en = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("en", int'(en), int'(exp_en));
      check("gnt_id", int'(gnt_id), m_last);
      check("busy", int'(busy), int'(m_owner >= 0 || m_quiet > 0));
      check("en_onehot0", int'($onehot0(en)), 1);
      if (en != '0) begin
        if (last_en_nz != '0 && en != last_en_nz)
          check("turnaround_gap", int'(zero_run >= GAP), 1);
        last_en_nz = en;
        zero_run   = 0;
      end else begin
        zero_run++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state held across several edges.
    repeat (2) step();
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gnt", int'(gnt_id), 0);
    rst = 1'b0;

    // Single request: grant after edge 1, release at edge 4, idle after edge 5.
    req = 4'b0001;
    step();
    check("s1_grant_en", int'(en), 1);
    check("s1_grant_busy", int'(busy), 1);
    step(); step();
    req = 4'b0000;
    step();
    check("s1_release_en", int'(en), 0);
    check("s1_turn_busy", int'(busy), 1);
    step();
    check("s1_idle_busy", int'(busy), 0);

    // Forced release of a lone requester and regrant after the gap.
    req = 4'b0100;
    step();
    check("s2_grant", int'(en), 4);
    check("s2_gnt_id", int'(gnt_id), 2);
    for (int i = 1; i < 8; i++) begin
      step();
      check("s2_hold", int'(en), 4);
    end
    step();
    check("s2_forced_off", int'(en), 0);
    step();
    check("s2_regrant", int'(en), 4);
    req = 4'b0000;
    step(); step();

    // Fairness under full contention: 0,1,2,3,0, eight cycles each.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check("s3_owner", int'(en), 1 << (g % 4));
      end
      step();
      check("s3_gap", int'(en), 0);
    end
    req = 4'b0000;
    step(); step();

    // Pointer skip: after requester 1 releases, 0 beats 1.
    do_reset();
    req = 4'b0010;
    step();
    check("s4_grant1", int'(en), 2);
    req = 4'b0000;
    step();
    check("s4_release", int'(en), 0);
    req = 4'b0011;
    step();
    check("s4_skip", int'(en), 1);
    check("s4_gnt_id", int'(gnt_id), 0);
    req = 4'b0000;
    step(); step(); step();

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0010;
    step();
    check("s5_grant", int'(en), 2);
    #2 rst = 1'b1;
    #1;
    check("s5_async_en", int'(en), 0);
    check("s5_async_busy", int'(busy), 0);
    check("s5_async_gnt", int'(gnt_id), 0);
    rst = 1'b0;
    req = 4'b1000;
    step();
    check("s5_after_rst", int'(en), 8);
    check("s5_gnt_id", int'(gnt_id), 3);

    // Randomized traffic, occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if ($urandom_range(0, 9) == 0)
        req = req ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 29) == 0)
        req = N'($urandom);
      if ($urandom_range(0, 999) == 0)
        do_reset();
    end
    req = 4'b0000;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter N, default 4, meaning number of requesters sharing one tri-state bus.
REQ-002 Parameter MAXHOLD, default 8, meaning maximum consecutive cycles one requester keeps its driver enabled.
REQ-003 Parameter GAP, default 1, meaning number of all-disabled turnaround cycles between any two grants.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N  level request per requester; bit i high means requester i wants the bus.
REQ-007 en  output  N  tri-state driver enables, one bit per requester, wired directly to the driver en pins.
REQ-008 gnt_id  output  clog2(N)  index of the current or most recent grantee.
REQ-009 busy  output  1  high whenever the bus is granted or in turnaround.

Function
REQ-010 The FSM shall have exactly three states: IDLE, GRANT, TURN.
REQ-011 en, gnt_id and busy shall be registered outputs with no combinational path from req.
REQ-012 en shall be all-zero or one-hot in every cycle, including across reset release.
REQ-013 en shall be all-zero in IDLE and TURN.
REQ-014 In IDLE with req nonzero at an edge, the FSM shall select the first requester at or after the round-robin pointer, modulo N.
REQ-015 On that same edge, the FSM shall set en[sel], set gnt_id to sel, enter GRANT, and clear the hold counter; grant latency is one edge.
REQ-016 In GRANT, the hold counter shall increment every cycle that en is high.
REQ-017 GRANT shall end when req[gnt_id] is sampled low, or when the counter shows MAXHOLD cycles elapsed, whichever comes first.
REQ-018 When GRANT ends, the FSM shall clear en, advance the pointer to gnt_id+1 mod N, and enter TURN.
REQ-019 If req drop and MAXHOLD expiry coincide, the FSM shall perform a single release.
REQ-020 TURN shall last exactly GAP cycles.
REQ-021 On the last TURN edge with req nonzero, the FSM shall grant directly per REQ-014 and REQ-015, without passing through IDLE.
REQ-022 On the last TURN edge with req zero, the FSM shall enter IDLE.
REQ-023 Requests arriving or withdrawn during TURN shall be honoured only at the decision edge.
REQ-024 A lone requester that is forcibly released shall be regranted after GAP cycles.
REQ-025 Under continuous contention, each requester shall receive the bus at least once per N grants.
REQ-026 busy shall be low only in IDLE.
REQ-027 gnt_id shall hold its value through TURN and IDLE.

Reset
REQ-028 While rst is high, regardless of clk: en=0, busy=0, gnt_id=0, pointer=0, hold counter=0, state=IDLE.
REQ-029 Reset asserted mid-GRANT shall clear en immediately, without waiting for a clock edge.
REQ-030 The first grant after reset release shall follow REQ-014, with the pointer at 0.

Structure
REQ-031 A shared package shall hold the state enum, defaults for N, MAXHOLD and GAP, and the gnt_id width function.
REQ-032 The round-robin priority selector (pointer plus req in, index plus valid out) shall be the only sub-module, named rr_select.

Verification
REQ-033 Scenario 1, single request: reset; req=0001 at edge 1 -> en=0001 after edge 1; req low at edge 4 -> en=0000 after edge 4; IDLE after edge 5.
REQ-034 Scenario 2, forced release: req=0100 held steady -> en=0100 for exactly 8 cycles, then 1 zero cycle, then en=0100 again.
REQ-035 Scenario 3, fairness: req=1111 held -> grant order 0,1,2,3,0; each grant 8 cycles; one zero cycle between grants.
REQ-036 Scenario 4, pointer skip: gnt 1 just released, req=0011 -> next grant goes to 0, not 1.
REQ-037 Scenario 5, reset mid-grant: rst pulsed between edges while en=0010 -> en=0000 before the next edge; after release, req=1000 -> en=1000.
REQ-038 Scenario 6, all runs: an assertion checks that en is one-hot or zero every cycle and that en is zero for at least GAP cycles between different grantees.
